// File: rtl/rm14_pkg.sv
// Shared definitions for the RM(1,4) encoder/decoder pair: sizes, FSM states
// and the parity tap table.
package rm14_pkg;

    localparam int MSG_W = 5;
    localparam int CW_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } rm14_state_e;

    // Each entry selects the message bits (m0 leftmost) XORed into parity bit c5..c15
    localparam logic [0:MSG_W-1] PAR_TAP [MSG_W:CW_W-1] = '{
        5'b11100,   // c5
        5'b11010,   // c6
        5'b11001,   // c7
        5'b10110,   // c8
        5'b10101,   // c9
        5'b10011,   // c10
        5'b01110,   // c11
        5'b01101,   // c12
        5'b01011,   // c13
        5'b00111,   // c14
        5'b11111    // c15
    };

endpackage

// File: rtl/rm14_encode_comb.sv
// Combinational systematic encoder: message bits pass straight through,
// parity bits come from the shared tap table.
module rm14_encode_comb
    import rm14_pkg::*;
(
    input  logic [0:MSG_W-1] msg,
    output logic [0:CW_W-1]  codeword
);

    always_comb begin
        codeword          = '0;
        codeword[0:MSG_W-1] = msg;
        for (int i = MSG_W; i < CW_W; i++) begin
            codeword[i] = ^(msg & PAR_TAP[i]);
        end
    end

endmodule

// File: rtl/rm14_encoder_tx.sv
// Encoder transmit stage: one-deep output register with valid/ready flow control,
// error-mask injection, a 32-message self-sweep FSM and frame/injection counters.
module rm14_encoder_tx
    import rm14_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [0:4]        msg,
    input  logic [0:15]       err_mask,
    input  logic              err_en,
    input  logic              start,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic [0:15]       r_out,
    output logic [0:15]       cw_clean,
    output logic [4:0]        err_weight,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  inj_cnt
);

    function automatic logic [4:0] popcount16(input logic [0:CW_W-1] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < CW_W; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    rm14_state_e       state;
    logic [4:0]        sweep_idx;
    logic              out_free;
    logic              accept;
    logic [0:MSG_W-1]  src_msg;
    logic [0:CW_W-1]   cw_enc;
    logic [0:CW_W-1]   eff_mask;

    // The sweep source bypasses msg_ready, which only advertises the external port
    assign out_free   = !cw_valid || cw_ready;
    assign msg_ready  = rst_n && out_free && (state == ST_IDLE);
    assign accept     = (state == ST_SWEEP) ? out_free : (msg_valid && msg_ready);
    assign src_msg    = (state == ST_SWEEP) ? sweep_idx : msg;
    assign eff_mask   = err_en ? err_mask : '0;
    assign sweep_busy = (state == ST_SWEEP);
    assign sweep_done = (state == ST_DONE);

    rm14_encode_comb u_enc (
        .msg      (src_msg),
        .codeword (cw_enc)
    );

    // Output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cw_valid   <= 1'b0;
            r_out      <= '0;
            cw_clean   <= '0;
            err_weight <= '0;
            frame_cnt  <= '0;
            inj_cnt    <= '0;
            state      <= ST_IDLE;
            sweep_idx  <= '0;
        end else begin
            if (accept) begin
                cw_valid   <= 1'b1;
                cw_clean   <= cw_enc;
                r_out      <= cw_enc ^ eff_mask;
                err_weight <= popcount16(eff_mask);
            end else if (cw_ready) begin
                cw_valid   <= 1'b0;
            end

            if (cw_valid && cw_ready) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                if (err_weight != 5'd0) begin
                    inj_cnt <= inj_cnt + CNT_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SWEEP;
                        sweep_idx <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (accept) begin
                        sweep_idx <= sweep_idx + 5'd1;
                        if (sweep_idx == 5'd31) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rm14_encoder_tx.md
RM14_ENCODER_TX -- requirements
Module: rm14_encoder_tx

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the frame and injected-error counters.
REQ-002 Port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising clk edge.
REQ-004 Port msg_valid, input, 1: the external message is valid.
REQ-005 Port msg_ready, output, 1: the block accepts the external message this cycle.
REQ-006 Port msg, input, [0:4]: message bits m0..m4, where bit 0 is the MSB.
REQ-007 Port err_mask, input, [0:15]: channel error pattern, sampled with each accepted message.
REQ-008 Port err_en, input, 1: when 1, err_mask is applied; when 0, the mask is treated as all-zero.
REQ-009 Port start, input, 1: a pulse that requests an automatic sweep of all 32 messages.
REQ-010 Port cw_valid, output, 1: r_out, cw_clean and err_weight are valid.
REQ-011 Port cw_ready, input, 1: the downstream decoder consumes the word.
REQ-012 Port r_out, output, [0:15]: received word, equal to cw_clean XOR the effective mask.
REQ-013 Port cw_clean, output, [0:15]: the uncorrupted codeword.
REQ-014 Port err_weight, output, [4:0]: popcount of the effective mask.
REQ-015 Port sweep_busy, output, 1: the FSM is in SWEEP.
REQ-016 Port sweep_done, output, 1: a one-cycle pulse when a sweep completes.
REQ-017 Port frame_cnt, output, [CNT_W-1:0]: number of words consumed downstream.
REQ-018 Port inj_cnt, output, [CNT_W-1:0]: number of consumed words with err_weight greater than 0.

Function
REQ-019 The encoding SHALL be systematic: c[0:4] = m[0:4].
REQ-020 The parity bits SHALL be c5=m0^m1^m2, c6=m0^m1^m3, c7=m0^m1^m4, c8=m0^m2^m3, c9=m0^m2^m4, c10=m0^m3^m4, c11=m1^m2^m3, c12=m1^m2^m4, c13=m1^m3^m4, c14=m2^m3^m4, c15=m0^m1^m2^m3^m4, so that every syndrome of the downstream decoder is zero.
REQ-021 A message SHALL be accepted when (source valid AND msg_ready); r_out, cw_clean and err_weight SHALL be registered and cw_valid SHALL rise on the next edge (latency 1 cycle).
REQ-022 The output register SHALL load whenever a message is accepted, and msg_ready SHALL equal (!cw_valid OR cw_ready) AND state==IDLE.
REQ-023 The outputs SHALL be held stable while cw_valid=1 and cw_ready=0.
REQ-024 On a simultaneous consume and accept, the output SHALL update with no bubble, giving a throughput of 1 word per clk.
REQ-025 FSM states SHALL be IDLE, SWEEP and DONE.
REQ-026 IDLE SHALL go to SWEEP on start=1; the sweep index SHALL be cleared to 0 on that transition.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 In SWEEP, the internal source SHALL present msg=index with valid=1; err_mask and err_en SHALL still be taken from the ports; the external msg_valid SHALL be ignored.
REQ-029 The sweep index SHALL increment on each accept, and the FSM SHALL go to DONE on the accept of index 31.
REQ-030 DONE SHALL last one cycle with sweep_done=1 and then return to IDLE.
REQ-031 frame_cnt SHALL increment on every (cw_valid AND cw_ready) and wrap modulo 2^CNT_W.
REQ-032 inj_cnt SHALL increment on the same event when err_weight is not 0, and wrap modulo 2^CNT_W.

Reset
REQ-033 While rst_n=0 at the clk edge: cw_valid=0, r_out=0, cw_clean=0, err_weight=0, frame_cnt=0, inj_cnt=0, state=IDLE, sweep index=0, sweep_busy=0, sweep_done=0.
REQ-034 A reset in the middle of a sweep or a stall SHALL discard the in-flight word with no sweep_done pulse.
REQ-035 msg_ready SHALL be 0 during the reset cycle.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, MSG_W=5, CW_W=16 and the parity index table used by this block and the decoder.
REQ-037 One combinational sub-module, rm14_encode_comb (msg[0:4] to codeword[0:15]), SHALL be reusable by the bench as the reference model.

Verification
REQ-038 Encode with msg=5'b10100, err_en=0 -> one cycle later cw_valid=1, cw_clean=r_out=16'hA33A, err_weight=0.
REQ-039 Same msg, err_en=1, err_mask=16'h8000 -> r_out=16'h233A, err_weight=1; after consume, inj_cnt=1.
REQ-040 Backpressure: cw_ready=0 for 5 cycles with msg_valid=1 -> msg_ready=0 and outputs stable; at cw_ready=1 the next word follows on the next cycle.
REQ-041 Sweep: start pulse with cw_ready=1 -> 32 words, cw_clean = encode(0..31) in order, sweep_done pulses once, frame_cnt=32.
REQ-042 Reset mid-sweep after 10 words -> all outputs at reset values; a new start restarts from msg=0.
REQ-043 Counter wrap with CNT_W=4: 17 consumes -> frame_cnt=1.
